can_tx_framer: RTL and testbench

Serialises a CAN 2.0A base-format frame (11-bit ID, 0–8 data bytes) onto the bus one bit per `bit_tick`. It inserts bit stuffing and appends the CRC-15 (polynomial 0x4599). It is the transmit counterpart of the receive-side CRC divider: a receiver dividing the destuffed bits SOF..CRC of a frame from this block ends with remainder zero. It also monitors `rx` for arbitration loss and acknowledgement. Bit timing and sample-point generation (`bit_tick`) and bus-idle detection are outside this block; the host issues `req` only when the bus is idle.

---
 rtl/can_tx_framer.sv | 212 +++++++++++++++++++++
 tb/tb_can_tx_framer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_framer.sv
// CAN 2.0A base-frame transmitter: serialises SOF..IFS one bit per bit_tick with
// bit stuffing and CRC-15, detects arbitration loss and captures the ACK slot.
module can_tx_framer #(
  parameter logic [14:0] POLY = 15'h4599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_tick,
  input  logic        req,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  input  logic        rx,
  output logic        tx,
  output logic        ready,
  output logic        done,
  output logic        acked,
  output logic        arb_lost
);

  typedef enum logic [3:0] {
    StIdle, StStart, StSof, StArb, StCtrl, StData, StCrc,
    StCrcDelim, StAck, StAckDelim, StEof, StIfs
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [14:0] crc_q, crc_d;
  logic [2:0]  run_q, run_d;
  logic        stuff_q, stuff_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        acked_q, acked_d;
  logic        arb_q, arb_d;

  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic [3:0]  nbytes_q;
  logic        load;

  state_e      adv_state, tgt_state;
  logic [5:0]  adv_cnt, tgt_cnt, data_last;
  logic        tgt_bit, nxt, ins_stuff, lose, in_stuff_region;
  logic [14:0] crc_step;

  assign data_last = 6'({nbytes_q, 3'b000} - 7'd1);

  // Field position following the current real bit.
  always_comb begin
    adv_state = state_q;
    adv_cnt   = cnt_q + 6'd1;
    case (state_q)
      StIdle:  begin adv_state = StIdle; adv_cnt = '0; end
      StStart: begin adv_state = StSof;  adv_cnt = '0; end
      StSof:   begin adv_state = StArb;  adv_cnt = '0; end
      StArb:   if (cnt_q == 6'd11) begin adv_state = StCtrl; adv_cnt = '0; end
      StCtrl: begin
        if (cnt_q == 6'd5) begin
          adv_cnt = '0;
          if (nbytes_q != 4'd0) adv_state = StData;
          else                  adv_state = StCrc;
        end
      end
      StData:     if (cnt_q == data_last) begin adv_state = StCrc; adv_cnt = '0; end
      StCrc:      if (cnt_q == 6'd14) begin adv_state = StCrcDelim; adv_cnt = '0; end
      StCrcDelim: begin adv_state = StAck;      adv_cnt = '0; end
      StAck:      begin adv_state = StAckDelim; adv_cnt = '0; end
      StAckDelim: begin adv_state = StEof;      adv_cnt = '0; end
      StEof:      if (cnt_q == 6'd6) begin adv_state = StIfs; adv_cnt = '0; end
      StIfs:      if (cnt_q == 6'd2) begin adv_state = StIdle; adv_cnt = '0; end
      default:    begin adv_state = StIdle; adv_cnt = '0; end
    endcase
  end

  // While a stuff bit is on the bus, state/cnt already point at the pending real bit.
  always_comb begin
    tgt_state = adv_state;
    tgt_cnt   = adv_cnt;
    if (stuff_q) begin
      tgt_state = state_q;
      tgt_cnt   = cnt_q;
    end
  end

  always_comb begin
    tgt_bit = 1'b1;
    case (tgt_state)
      StSof:   tgt_bit = 1'b0;
      StArb:   tgt_bit = (tgt_cnt < 6'd11) ? id_q[4'(10 - tgt_cnt)] : rtr_q;
      StCtrl:  tgt_bit = (tgt_cnt < 6'd2) ? 1'b0 : dlc_q[2'(5 - tgt_cnt)];
      StData:  tgt_bit = data_q[6'(63 - tgt_cnt)];
      StCrc:   tgt_bit = crc_q[4'(14 - tgt_cnt)];
      default: tgt_bit = 1'b1;
    endcase
  end

  assign nxt      = tgt_bit ^ crc_q[14];
  assign crc_step = {crc_q[13:0], 1'b0} ^ (nxt ? POLY : 15'd0);

  assign in_stuff_region = state_q inside {StSof, StArb, StCtrl, StData, StCrc};
  assign ins_stuff       = !stuff_q && in_stuff_region && (run_q == 3'd5);
  assign lose            = !stuff_q && (state_q == StArb) && tx_q && !rx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    run_d   = run_q;
    stuff_d = stuff_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    acked_d = acked_q;
    arb_d   = 1'b0;
    load    = 1'b0;
    if (ready_q) begin
      if (req) begin
        load    = 1'b1;
        ready_d = 1'b0;
        acked_d = 1'b0;
        state_d = StStart;
        cnt_d   = '0;
        crc_d   = '0;
        stuff_d = 1'b0;
        tx_d    = 1'b1;
      end
    end else if (bit_tick) begin
      if (lose) begin
        state_d = StIdle;
        cnt_d   = '0;
        stuff_d = 1'b0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        arb_d   = 1'b1;
      end else begin
        if (!stuff_q && state_q == StAck) acked_d = ~rx;
        state_d = tgt_state;
        cnt_d   = tgt_cnt;
        if (ins_stuff) begin
          tx_d    = ~tx_q;
          stuff_d = 1'b1;
          run_d   = 3'd1;
        end else begin
          tx_d    = tgt_bit;
          stuff_d = 1'b0;
          if (tgt_bit != tx_q)    run_d = 3'd1;
          else if (run_q != 3'd7) run_d = run_q + 3'd1;
          if (tgt_state inside {StSof, StArb, StCtrl, StData}) crc_d = crc_step;
          if (tgt_state == StIdle) begin
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      crc_q   <= '0;
      run_q   <= '0;
      stuff_q <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      acked_q <= 1'b0;
      arb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      run_q   <= run_d;
      stuff_q <= stuff_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      acked_q <= acked_d;
      arb_q   <= arb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      rtr_q    <= 1'b0;
      dlc_q    <= '0;
      data_q   <= '0;
      nbytes_q <= '0;
    end else if (load) begin
      id_q   <= id;
      rtr_q  <= rtr;
      dlc_q  <= dlc;
      data_q <= data;
      if (rtr)         nbytes_q <= 4'd0;
      else if (dlc[3]) nbytes_q <= 4'd8;
      else             nbytes_q <= dlc;
    end
  end

  assign tx       = tx_q;
  assign ready    = ready_q;
  assign done     = done_q;
  assign acked    = acked_q;
  assign arb_lost = arb_q;

endmodule

// File: tb/tb_can_tx_framer.sv
// Randomised and directed bench for can_tx_framer against a list-based frame model.
module tb_can_tx_framer;

  logic        clk = 1'b0;
  logic        rst, bit_tick, req, rtr, rx;
  logic [10:0] id;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        tx, ready, done, acked, arb_lost;

  int n_cmp = 0;
  int n_bad = 0;

  can_tx_framer dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .req(req), .id(id), .rtr(rtr),
    .dlc(dlc), .data(data), .rx(rx), .tx(tx), .ready(ready), .done(done),
    .acked(acked), .arb_lost(arb_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic r);
    bit_tick = t;
    rx       = r;
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
  endtask

  function automatic logic [14:0] crc_of(input logic bits[$]);
    logic [14:0] c = '0;
    logic        n;
    foreach (bits[k]) begin
      n = bits[k] ^ c[14];
      c = {c[13:0], 1'b0};
      if (n) c = c ^ 15'h4599;
    end
    return c;
  endfunction

  task automatic run_frame(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                           input logic [63:0] fdata, input logic ack_dom, input logic lose,
                           input logic hold_req, input logic tick_acc, input int abort_after,
                           output logic [63:0] txv);
    logic        ub[$];
    logic        sb[$];
    int          src[$];
    logic        obs[$];
    logic        du[$];
    logic [14:0] c;
    logic        last, rxv;
    int          nb, run, nst, ack_pos, lose_pos, maxrun, skip;
    txv = '0;
    // Unstuffed SOF..data, then CRC over it.
    ub.push_back(1'b0);
    for (int i = 10; i >= 0; i--) ub.push_back(fid[i]);
    ub.push_back(frtr);
    ub.push_back(1'b0);
    ub.push_back(1'b0);
    for (int i = 3; i >= 0; i--) ub.push_back(fdlc[i]);
    nb = frtr ? 0 : ((fdlc > 4'd8) ? 8 : int'(fdlc));
    for (int b = 0; b < nb * 8; b++) ub.push_back(fdata[63-b]);
    c = crc_of(ub);
    for (int i = 14; i >= 0; i--) ub.push_back(c[i]);
    run  = 0;
    last = 1'b1;
    foreach (ub[k]) begin
      sb.push_back(ub[k]);
      src.push_back(k);
      run  = (ub[k] == last) ? run + 1 : 1;
      last = ub[k];
      if (run == 5) begin
        sb.push_back(~ub[k]);
        src.push_back(-1);
        last = ~ub[k];
        run  = 1;
      end
    end
    nst     = sb.size();
    ack_pos = nst + 1;
    for (int i = 0; i < 13; i++) sb.push_back(1'b1);
    lose_pos = -1;
    if (lose) begin
      for (int p = 0; p < nst; p++) begin
        if (lose_pos < 0 && src[p] >= 1 && src[p] <= 12 && sb[p]) lose_pos = p;
      end
    end

    id = fid; rtr = frtr; dlc = fdlc; data = fdata; req = 1'b1;
    step(tick_acc, 1'b1);
    if (!hold_req) req = 1'b0;
    id = 11'($urandom); rtr = 1'($urandom); dlc = 4'($urandom); data = {$urandom, $urandom};
    chk("accept", {60'd0, tx, ready, done, acked}, 64'b1000);

    for (int k = 0; k <= sb.size(); k++) begin
      rxv = (k == 0) ? 1'b1 : sb[k-1];
      repeat ($urandom_range(0, 2)) step(1'b0, rxv);
      if (k > 0 && k - 1 == ack_pos && ack_dom) rxv = 1'b0;
      if (k > 0 && k - 1 == lose_pos) begin
        req = 1'b0;
        step(1'b1, 1'b0);
        chk("arb_lost", {60'd0, tx, ready, done, arb_lost}, 64'b1101);
        step(1'b0, 1'b1);
        chk("arb_pulse", {62'd0, arb_lost, ready}, 64'b01);
        for (int j = 0; j < 3; j++) begin
          step(1'b1, 1'b1);
          chk("post_lose", {60'd0, tx, ready, done, arb_lost}, 64'b1100);
        end
        return;
      end
      step(1'b1, rxv);
      if (k == sb.size()) begin
        chk("done", {60'd0, tx, ready, done, arb_lost}, 64'b1110);
        chk("acked", {63'd0, acked}, {63'd0, ack_dom});
      end else begin
        chk($sformatf("bit%0d", k), {60'd0, tx, ready, done, arb_lost}, {60'd0, sb[k], 3'b000});
        obs.push_back(tx);
        txv = {txv[62:0], tx};
      end
      if (k == abort_after) return;
    end
    req = 1'b0;
    step(1'b0, 1'b1);
    chk("done_pulse", {62'd0, done, ready}, 64'b01);

    // Receiver view: destuff observed SOF..CRC and divide; also bound the runs.
    run = 0; last = 1'b1; maxrun = 0; skip = 0;
    for (int p = 0; p < nst; p++) begin
      run  = (obs[p] == last) ? run + 1 : 1;
      last = obs[p];
      if (run > maxrun) maxrun = run;
    end
    run = 0; last = 1'b1;
    for (int p = 0; p < nst; p++) begin
      if (skip != 0) begin
        skip = 0; last = obs[p]; run = 1;
      end else begin
        du.push_back(obs[p]);
        run  = (obs[p] == last) ? run + 1 : 1;
        last = obs[p];
        if (run == 5) skip = 1;
      end
    end
    chk("max_run", {63'd0, maxrun > 5}, 64'd0);
    chk("remainder", {49'd0, crc_of(du)}, 64'd0);
  endtask

  logic [63:0] txv;
  logic [52:0] s1_lit;
  logic        lz;

  initial begin
    s1_lit = 53'b000001_000001_000001_000001_000001_000001_0000_1111111111111;
    rst = 1'b1; bit_tick = 1'b0; req = 1'b0; rx = 1'b1;
    id = '0; rtr = 1'b0; dlc = '0; data = '0;
    #3;
    chk("reset", {59'd0, tx, ready, done, acked, arb_lost}, 64'b11000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1);

    // All-zero frame: 6 stuff bits, CRC 0, ACK dominant.
    run_frame(11'h000, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1, txv);
    chk("s1_tx", txv, {11'd0, s1_lit});
    run_frame(11'h123, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, 1'b0, -1, txv);
    run_frame(11'h7FF, 1'b1, 4'd15, 64'hDEAD_BEEF_0000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, -1, txv);
    run_frame(11'h400, 1'b0, 4'd2, 64'hA5A5_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, -1, txv);
    run_frame(11'h2AA, 1'b0, 4'd3, 64'h1122_3300_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, -1, txv);

    // Abandon mid-DATA with an asynchronous reset, then repeat the all-zero frame.
    run_frame(11'h155, 1'b0, 4'd8, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0, 1'b0, 1'b0, 28, txv);
    rst = 1'b1;
    #1;
    chk("mid_reset", {59'd0, tx, ready, done, acked, arb_lost}, 64'b11000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1);
    run_frame(11'h000, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1, txv);
    chk("s1_after_reset", txv, {11'd0, s1_lit});

    // req held through the frame, tick coincident with acceptance.
    run_frame(11'h3C1, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, -1, txv);

    for (int f = 0; f < 12; f++) begin
      lz = ($urandom_range(0, 3) == 0);
      run_frame(11'($urandom), ($urandom_range(0, 4) == 0), 4'($urandom),
                {$urandom, $urandom}, 1'($urandom), lz, !lz && ($urandom_range(0, 2) == 0),
                1'($urandom), -1, txv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
